mos6502s_store_unit: RTL and testbench
======================================

Name: mos6502s_store_unit

Overview:
- Write-side counterpart to the CPU register file: takes a store request (STA/STX/STY) and drives the selected register value onto the memory write bus.
- Snapshots the register value, address and select at request acceptance, then runs a write handshake with the memory side.
- Supports variable wait states and a bounded timeout.
- Sits between the register file outputs (a/x/y) and the external memory bus; the sequencer issues requests.

Parameters:
- TIMEOUT, 16, max consecutive WRITE cycles with mem_ready low before abort; 0 disables the timeout.
- ADDR_W, 16, memory address width.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- a  input  8  accumulator value from register file
- x  input  8  X index value from register file
- y  input  8  Y index value from register file
- req_valid  input  1  store request present
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_sel  input  2  source select: 00=A, 01=X, 10=Y, 11=zero/reserved
- req_addr  input  ADDR_W  effective address of store
- mem_addr  output  ADDR_W  write address
- mem_wdata  output  8  write data
- mem_we  output  1  write strobe, held until accepted
- mem_ready  input  1  memory accepts write this cycle when mem_we=1
- done  output  1  one-cycle pulse: write completed
- err  output  1  one-cycle pulse: timeout abort or rejected request
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset values: state=IDLE, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0, busy=0, req_ready=1, wait counter=0.
- States: IDLE, WRITE.
- IDLE:
  - req_ready=1.
  - On req_valid=1 at a rising edge, capture req_addr into mem_addr and the selected register into mem_wdata (value sampled at that edge), then go to WRITE.
  - Later changes on a/x/y or req_* do not affect the in-flight write.
- WRITE:
  - mem_we=1, req_ready=0, busy=1. mem_addr and mem_wdata are held stable.
  - Edge with mem_ready=1: mem_we drops, state returns to IDLE, done=1 for exactly the following cycle.
  - Edge with mem_ready=0: wait counter increments.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT: abort to IDLE, mem_we=0, err=1 for one cycle, done stays 0.
  - Counter clears on entry to WRITE.
- Latency: request accepted at edge N → mem_we high in cycle N+1. With mem_ready high in N+1: done and req_ready high in cycle N+2. Minimum throughput is one store per 2 cycles.
- A request may be accepted in the same cycle done is high (back-to-back stores).
- mem_ready while mem_we=0 is ignored.
- req_sel=11 without the optional feature:
  - The request is accepted and consumed (req_ready=1 handshake occurs).
  - No write is issued, state stays IDLE, err=1 the next cycle.
- done and err are never high in the same cycle.
- Reset during WRITE: mem_we=0 in the cycle after the reset edge, no done and no err, the in-flight store is dropped.
- mem_wdata and mem_addr retain their last values in IDLE (not zeroed after completion).

Optional Feature:
- Macro: MOS6502S_STZ_EN.
- Defined: req_sel=11 is a valid 65C02 STZ store; the write proceeds like any other store with mem_wdata=8'h00, completes with done, and never raises err.
- Undefined: req_sel=11 is rejected as described above (err pulse, no bus write).

Test Plan:
- Reset, a=8'h5A, req_sel=00, req_addr=16'h0200, mem_ready tied 1 → mem_we=1 one cycle with addr 0200/data 5A; done pulses one cycle later; req_ready back to 1.
- x=8'h11 at accept, x changed to 8'hFF next cycle, mem_ready low for 3 cycles then high → mem_wdata stays 8'h11 throughout; mem_we high 4 cycles; single done.
- TIMEOUT=4, y=8'h33 store, mem_ready held 0 → mem_we drops after 4 wait cycles; err pulses once; done never asserts; req_ready=1 afterwards.
- req_sel=11, req_addr=16'h00FF: with MOS6502S_STZ_EN → write of 8'h00 to 00FF and done; without it → no mem_we, err pulse one cycle after accept.
- Back-to-back: STA 0300 (a=8'h01), then STX 0301 (x=8'h02) presented during the done cycle, mem_ready=1 → two writes in cycles N+1 and N+3, two done pulses.
- rst asserted mid-WRITE with mem_ready=0 → mem_we=0, busy=0, req_ready=1 next cycle; no done or err.

Source files
------------

// File: rtl/mos6502s_store_unit.sv
// mos6502s_store_unit
// Write-side counterpart of the 6502 register file. It accepts a store request
// (STA/STX/STY), snapshots the selected register, the address and the select at
// acceptance, and then holds a write strobe on the memory bus until the memory
// accepts it or the wait-state budget runs out.
//
// Build option: define MOS6502S_STZ_EN to treat req_sel=11 as a 65C02 STZ
// (store of 8'h00). Without it, req_sel=11 is consumed and rejected with err.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   a, x, y               register file values (sampled at acceptance only)
//   req_valid/req_ready   request handshake (req_ready high only in IDLE)
//   req_sel, req_addr     source select (00=A 01=X 10=Y 11=zero) and address
//   mem_addr, mem_wdata   write address/data, stable through the write
//   mem_we, mem_ready     write strobe and memory acceptance
//   done, err             one-cycle completion / abort-or-reject pulses
//   busy                  high whenever a write is in flight
module mos6502s_store_unit #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        a,
  input  logic [7:0]        x,
  input  logic [7:0]        y,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_sel,
  input  logic [ADDR_W-1:0] req_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic              done,
  output logic              err,
  output logic              busy
);

  // Counter only needs to reach TIMEOUT; keep at least one bit when disabled.
  localparam int unsigned CNT_W = (TIMEOUT < 32'd2) ? 32'd1 : $clog2(TIMEOUT + 32'd1);
  localparam logic [CNT_W:0] TO_LIM = (CNT_W + 1)'(TIMEOUT);

`ifdef MOS6502S_STZ_EN
  localparam logic STZ_EN = 1'b1;
`else
  localparam logic STZ_EN = 1'b0;
`endif

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] wait_cnt_r;
  logic [CNT_W:0]   wait_nxt_s;
  logic [7:0]       sel_data_s;
  logic             sel_ok_s;

  // Source mux: pick the register named by req_sel; select 11 stores zero.
  always_comb begin
    sel_data_s = 8'h00;
    case (req_sel)
      2'b00:   sel_data_s = a;
      2'b01:   sel_data_s = x;
      2'b10:   sel_data_s = y;
      2'b11:   sel_data_s = 8'h00;
      default: sel_data_s = 8'h00;
    endcase
  end

  // Request legality: select 11 is only a real store when STZ is built in.
  always_comb begin
    sel_ok_s = 1'b1;
    if (req_sel == 2'b11) begin
      sel_ok_s = STZ_EN;
    end else begin
      sel_ok_s = 1'b1;
    end
  end

  // Wait count after one more not-ready cycle, one bit wider so it can hit TIMEOUT.
  always_comb begin
    wait_nxt_s = {1'b0, wait_cnt_r} + {{CNT_W{1'b0}}, 1'b1};
  end

  // Store FSM with all bus and status outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= {ADDR_W{1'b0}};
      mem_wdata  <= 8'h00;
      done       <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      req_ready  <= 1'b1;
      wait_cnt_r <= {CNT_W{1'b0}};
    end else begin
      // Status pulses last exactly one cycle unless re-armed below.
      done <= 1'b0;
      err  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            if (sel_ok_s) begin
              mem_addr   <= req_addr;
              mem_wdata  <= sel_data_s;
              mem_we     <= 1'b1;
              busy       <= 1'b1;
              req_ready  <= 1'b0;
              wait_cnt_r <= {CNT_W{1'b0}};
              state_r    <= WRITE;
            end else begin
              // Reserved select: request is consumed but no bus write happens.
              err <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (mem_ready) begin
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            done      <= 1'b1;
            state_r   <= IDLE;
          end else if ((TIMEOUT != 32'd0) && (wait_nxt_s == TO_LIM)) begin
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            err       <= 1'b1;
            state_r   <= IDLE;
          end else begin
            wait_cnt_r <= wait_nxt_s[CNT_W-1:0];
          end
        end
        default: begin
          mem_we    <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mos6502s_store_unit.sv
// Self-checking bench for mos6502s_store_unit (TIMEOUT=4).
// Directed table of stores, a reset-during-write sequence and randomized
// stores checked against a transaction-level expectation of each store.
module tb_mos6502s_store_unit;
  localparam int TO = 4;
`ifdef MOS6502S_STZ_EN
  localparam bit STZ = 1'b1;
`else
  localparam bit STZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a, x, y;
  logic        req_valid, req_ready;
  logic [1:0]  req_sel;
  logic [15:0] req_addr, mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we, mem_ready, done, err, busy;

  int checks = 0;
  int errors = 0;
  logic [15:0] last_addr;
  logic [7:0]  last_data;

  mos6502s_store_unit #(.TIMEOUT(TO), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .a(a), .x(x), .y(y),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .req_addr(req_addr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_ready(mem_ready), .done(done), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] addr;
    logic [7:0]  a, x, y;
    int          waits;    // not-ready cycles before mem_ready rises
    int          gap;      // idle cycles after the store
    logic [7:0]  exp_data;
    int          exp_len;  // cycles mem_we is high
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_cycle(input string tag, input logic we, input logic bz, input logic rr,
                           input logic dn, input logic er, input logic [15:0] ad,
                           input logic [7:0] dt);
    chk({tag, ".mem_we"},    {15'd0, mem_we},    {15'd0, we});
    chk({tag, ".busy"},      {15'd0, busy},      {15'd0, bz});
    chk({tag, ".req_ready"}, {15'd0, req_ready}, {15'd0, rr});
    chk({tag, ".done"},      {15'd0, done},      {15'd0, dn});
    chk({tag, ".err"},       {15'd0, err},       {15'd0, er});
    chk({tag, ".mem_addr"},  mem_addr,           ad);
    chk({tag, ".mem_wdata"}, {8'd0, mem_wdata},  {8'd0, dt});
  endtask

  // Outcome of one store derived from the rules: which byte, how long the
  // strobe stays up, and whether it ends in done or err.
  function automatic void predict(input vec_t v, output logic [7:0] data, output int len,
                                  output logic dn, output logic er);
    case (v.sel)
      2'd0:    data = v.a;
      2'd1:    data = v.x;
      2'd2:    data = v.y;
      default: data = 8'h00;
    endcase
    if (v.sel == 2'd3 && !STZ) begin
      len = 0; dn = 1'b0; er = 1'b1;
    end else if (TO != 0 && v.waits >= TO) begin
      len = TO; dn = 1'b0; er = 1'b1;
    end else begin
      len = v.waits + 1; dn = 1'b1; er = 1'b0;
    end
  endfunction

  // Called just after a negedge sample with the unit able to accept.
  task automatic run_txn(input vec_t v, input string tag);
    req_valid = 1'b1; req_sel = v.sel; req_addr = v.addr;
    a = v.a; x = v.x; y = v.y;
    mem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    for (int k = 0; k < v.exp_len; k++) begin
      chk_cycle({tag, ".wr"}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, v.addr, v.exp_data);
      if (k == 0) begin
        // Disturb every source after acceptance; the write must not follow.
        req_valid = 1'($urandom_range(0, 1));
        req_sel = 2'($urandom_range(0, 3)); req_addr = 16'($urandom);
        a = ~v.a; x = ~v.x; y = ~v.y;
      end
      mem_ready = (k == v.waits);
      @(negedge clk);
    end
    if (v.exp_len > 0) begin
      last_addr = v.addr;
      last_data = v.exp_data;
    end
    chk_cycle({tag, ".end"}, 1'b0, 1'b0, 1'b1, v.exp_done, v.exp_err, last_addr, last_data);
    req_valid = 1'b0;
    mem_ready = 1'($urandom_range(0, 1));
    for (int g = 0; g < v.gap; g++) begin
      @(negedge clk);
      chk_cycle({tag, ".idle"}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, last_addr, last_data);
      mem_ready = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    vec_t v;
    //          sel    addr      a      x      y     w  g  data   len done  err
    vecs[0] = '{2'd0, 16'h0200, 8'h5A, 8'h00, 8'h00, 0, 1, 8'h5A, 1, 1'b1, 1'b0};
    vecs[1] = '{2'd1, 16'h1234, 8'h00, 8'h11, 8'hEE, 3, 0, 8'h11, 4, 1'b1, 1'b0};
    vecs[2] = '{2'd2, 16'h2000, 8'h00, 8'h00, 8'h33, 9, 1, 8'h33, 4, 1'b0, 1'b1};
    vecs[3] = '{2'd2, 16'h2001, 8'h00, 8'h00, 8'h44, 3, 0, 8'h44, 4, 1'b1, 1'b0};
    vecs[4] = '{2'd0, 16'h2002, 8'hA5, 8'h00, 8'h00, 4, 0, 8'hA5, 4, 1'b0, 1'b1};
`ifdef MOS6502S_STZ_EN
    vecs[5] = '{2'd3, 16'h00FF, 8'hFF, 8'hFF, 8'hFF, 0, 1, 8'h00, 1, 1'b1, 1'b0};
`else
    vecs[5] = '{2'd3, 16'h00FF, 8'hFF, 8'hFF, 8'hFF, 0, 1, 8'h00, 0, 1'b0, 1'b1};
`endif
    vecs[6] = '{2'd0, 16'h0300, 8'h01, 8'h00, 8'h00, 0, 0, 8'h01, 1, 1'b1, 1'b0};
    vecs[7] = '{2'd1, 16'h0301, 8'h00, 8'h02, 8'h00, 0, 2, 8'h02, 1, 1'b1, 1'b0};

    rst = 1'b1; req_valid = 1'b0; req_sel = 2'd0; req_addr = 16'h0000;
    a = 8'h00; x = 8'h00; y = 8'h00; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_cycle("reset", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
    last_addr = 16'h0000; last_data = 8'h00;
    rst = 1'b0;
    @(negedge clk);
    chk_cycle("post_reset", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);

    // Directed table; entries 6 and 7 run back-to-back through the done cycle.
    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset while the strobe is waiting: store dropped, no done or err.
    req_valid = 1'b1; req_sel = 2'd0; req_addr = 16'h0400; a = 8'h77;
    @(negedge clk);
    chk_cycle("rstw.wr", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0400, 8'h77);
    req_valid = 1'b0; mem_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk_cycle("rstw.rst", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
    rst = 1'b0; last_addr = 16'h0000; last_data = 8'h00;
    @(negedge clk);
    chk_cycle("rstw.after", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);

    // Randomized stores with expectations from predict().
    for (int i = 0; i < 40; i++) begin
      v.sel   = 2'($urandom_range(0, 3));
      v.addr  = 16'($urandom);
      v.a     = 8'($urandom);
      v.x     = 8'($urandom);
      v.y     = 8'($urandom);
      v.waits = $urandom_range(0, 6);
      v.gap   = $urandom_range(0, 2);
      predict(v, v.exp_data, v.exp_len, v.exp_done, v.exp_err);
      run_txn(v, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
